mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-port unified memory between the fetch stage (IF) and the memory-stage LSU (LS).
// - One transaction outstanding at a time; LS has priority; a starvation counter bounds IF wait.
// - Drives o_stall_fetch / o_stall_memory into the hazard unit while a requester is unserved.
// - i_flush (pc_sel redirect) discards a pending fetch response.
// PARAMETERS
// - AW          32  address width
// - DW          32  data width
// - MAX_STARVE  4   consecutive IF-losing arbitrations before IF is forced to win (>=1)
// PORTS
// - i_clk         in   1     clock, rising edge
// - i_reset       in   1     asynchronous, active-low reset
// - i_flush       in   1     fetch redirect; drop in-flight IF response
// - i_if_req      in   1     IF read request; held until o_if_rvalid
// - i_if_addr     in   AW    IF address
// - o_if_gnt      out  1     IF request accepted downstream (1-cycle pulse)
// - o_if_rvalid   out  1     IF read data valid (1-cycle pulse)
// - o_if_rdata    out  DW    IF read data
// - i_ls_req      in   1     LS request; held until done
// - i_ls_wren     in   1     1 = store, 0 = load
// - i_ls_addr     in   AW    LS address
// - i_ls_wdata    in   DW    store data
// - i_ls_bmask    in   DW/8  byte enables
// - o_ls_gnt      out  1     LS request accepted downstream (1-cycle pulse)
// - o_ls_rvalid   out  1     LS load data valid (1-cycle pulse)
// - o_ls_rdata    out  DW    LS load data
// - o_mem_req     out  1     downstream request
// - o_mem_wren    out  1     downstream write enable
// - o_mem_addr    out  AW    downstream address
// - o_mem_wdata   out  DW    downstream write data
// - o_mem_bmask   out  DW/8  downstream byte enables
// - i_mem_ready   in   1     downstream accepts o_mem_req this cycle
// - i_mem_rvalid  in   1     downstream read data valid
// - i_mem_rdata   in   DW    downstream read data
// - o_stall_fetch   out 1    = i_if_req & ~o_if_rvalid
// - o_stall_memory  out 1    = i_ls_req & ~(o_ls_rvalid | (o_ls_gnt & i_ls_wren))
// - o_busy        out  1     state != IDLE
// BEHAVIOUR
// - Reset (async): state IDLE; starve_cnt = 0; drop = 0; owner = IF.
//   All registered outputs are 0. Late i_mem_rvalid after reset is ignored.
// - FSM states IDLE, REQ, WAIT.
// - IDLE: arbitrate.
//   - If only one requester is active, it wins.
//   - If both are active: IF wins if starve_cnt == MAX_STARVE, else LS wins.
//   - Latch owner, wren, addr, wdata, bmask into registers; go to REQ.
//   - IF fetches always use wren = 0 and bmask = all ones.
// - starve_cnt updates at each arbitration:
//   - +1 (saturating) when IF requested and lost.
//   - Cleared when IF wins or i_if_req = 0.
// - REQ: o_mem_req = 1; mem fields come from the latched registers and stay stable.
//   - On i_mem_ready: pulse the owner's gnt.
//   - Store: return to IDLE.
//   - Load: go to WAIT.
// - WAIT: on i_mem_rvalid, go to IDLE.
//   - o_<owner>_rvalid = i_mem_rvalid, combinational same cycle, unless drop.
//   - o_<owner>_rdata = i_mem_rdata.
// - Latency: arbitrate T0, request T1 (if ready), rvalid >= T2.
//   One IDLE cycle always separates transactions.
// - Flush:
//   - i_flush while owner = IF in REQ or WAIT sets drop.
//   - The transaction completes downstream, but o_if_rvalid is suppressed; drop clears on return to IDLE.
//   - i_flush in IDLE, or while owner = LS, has no effect.
// - i_mem_rvalid in IDLE or REQ is ignored.
//   i_mem_ready in IDLE or WAIT is ignored.
// - Requester protocol: req, addr and data must stay stable from req rise until done.
//   Deasserting req earlier (except IF on flush) is a protocol violation; behaviour is undefined.
// TESTING
// - Lone IF read 0x100, ready=1, rvalid at T2 with rdata 0x00500093 ->
//   o_mem_req and o_if_gnt at T1; o_if_rvalid/data at T2; o_stall_fetch 1 at T0-T1, 0 at T2.
// - IF 0x104 and LS load 0x2000 together ->
//   LS transaction first, IF next; starve_cnt = 1 after the first arbitration.
// - LS requesting back-to-back while IF requests, MAX_STARVE=4 ->
//   IF wins the 5th arbitration; starve_cnt returns to 0.
// - LS store 0x7000 / 0xDEADBEEF / bmask 0xF, ready held low 3 cycles ->
//   o_mem_* stable for 3 cycles; o_ls_gnt pulses on the ready cycle; no rvalid; IDLE next cycle.
// - i_flush during IF WAIT, then rvalid 0x12345678 ->
//   o_if_rvalid stays 0; o_stall_fetch stays 1; FSM returns to IDLE.
// - Reset pulse in WAIT, then i_mem_rvalid ->
//   all outputs 0; state IDLE; no rvalid forwarded.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-port memory between instruction fetch (IF) and
// the load/store unit (LS): LS has priority, a starvation counter bounds IF wait.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,

    input  logic              i_if_req,
    input  logic [AW-1:0]     i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DW-1:0]     o_if_rdata,

    input  logic              i_ls_req,
    input  logic              i_ls_wren,
    input  logic [AW-1:0]     i_ls_addr,
    input  logic [DW-1:0]     i_ls_wdata,
    input  logic [DW/8-1:0]   i_ls_bmask,
    output logic              o_ls_gnt,
    output logic              o_ls_rvalid,
    output logic [DW-1:0]     o_ls_rdata,

    output logic              o_mem_req,
    output logic              o_mem_wren,
    output logic [AW-1:0]     o_mem_addr,
    output logic [DW-1:0]     o_mem_wdata,
    output logic [DW/8-1:0]   o_mem_bmask,
    input  logic              i_mem_ready,
    input  logic              i_mem_rvalid,
    input  logic [DW-1:0]     i_mem_rdata,

    output logic              o_stall_fetch,
    output logic              o_stall_memory,
    output logic              o_busy
);

    localparam int BW = DW / 8;
    localparam int SW = $clog2(MAX_STARVE + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    logic [1:0]    state_q,      state_d;
    logic          owner_q,      owner_d;
    logic          wren_q,       wren_d;
    logic [AW-1:0] addr_q,       addr_d;
    logic [DW-1:0] wdata_q,      wdata_d;
    logic [BW-1:0] bmask_q,      bmask_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          drop_q,       drop_d;

    logic starve_at_max;
    logic ls_wins;
    logic if_owned;
    logic in_req;
    logic in_wait;
    logic rsp_fire;

    assign starve_at_max = (starve_cnt_q == SW'(MAX_STARVE));
    // LS wins unless IF is idle-free and has already lost MAX_STARVE times in a row.
    assign ls_wins       = i_ls_req & (~i_if_req | ~starve_at_max);
    assign if_owned      = (owner_q == OWN_IF);
    assign in_req        = (state_q == ST_REQ);
    assign in_wait       = (state_q == ST_WAIT);
    assign rsp_fire      = in_wait & i_mem_rvalid;

    // NOTE: every _d gets its _q as default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        wren_d       = wren_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        bmask_d      = bmask_q;
        starve_cnt_d = starve_cnt_q;
        drop_d       = drop_q;

        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (i_if_req | i_ls_req) begin
                    state_d = ST_REQ;
                    if (ls_wins) begin
                        owner_d = OWN_LS;
                        wren_d  = i_ls_wren;
                        addr_d  = i_ls_addr;
                        wdata_d = i_ls_wdata;
                        bmask_d = i_ls_bmask;
                    end else begin
                        owner_d = OWN_IF;
                        wren_d  = 1'b0;
                        addr_d  = i_if_addr;
                        wdata_d = '0;
                        bmask_d = '1;
                    end
                    if (i_if_req && ls_wins) begin
                        if (!starve_at_max) starve_cnt_d = starve_cnt_q + 1'b1;
                    end else begin
                        starve_cnt_d = '0;
                    end
                end
            end
            ST_REQ: begin
                if (i_flush && if_owned) drop_d = 1'b1;
                if (i_mem_ready) begin
                    if (wren_q) begin
                        state_d = ST_IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (i_flush && if_owned) drop_d = 1'b1;
                if (i_mem_rvalid) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IF;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            bmask_q      <= '0;
            starve_cnt_q <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            wren_q       <= wren_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            bmask_q      <= bmask_d;
            starve_cnt_q <= starve_cnt_d;
            drop_q       <= drop_d;
        end
    end

    assign o_mem_req   = in_req;
    assign o_mem_wren  = wren_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_bmask = bmask_q;

    assign o_if_gnt    = in_req & i_mem_ready & if_owned;
    assign o_ls_gnt    = in_req & i_mem_ready & ~if_owned;

    // A redirect landing on the very response cycle is treated like an earlier flush.
    assign o_if_rvalid = rsp_fire & if_owned & ~drop_q & ~i_flush;
    assign o_ls_rvalid = rsp_fire & ~if_owned;
    assign o_if_rdata  = i_mem_rdata;
    assign o_ls_rdata  = i_mem_rdata;

    assign o_stall_fetch  = i_if_req & ~o_if_rvalid;
    assign o_stall_memory = i_ls_req & ~(o_ls_rvalid | (o_ls_gnt & i_ls_wren));
    assign o_busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory responder, auto-releasing
// requesters and ordered queues of expected downstream transactions and responses.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    typedef struct {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
    } mem_txn_t;

    typedef struct {
        logic        is_ls;
        logic [31:0] data;
    } rsp_t;

    logic        i_clk;
    logic        i_reset;
    logic        i_flush;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        i_ls_req;
    logic        i_ls_wren;
    logic [31:0] i_ls_addr;
    logic [31:0] i_ls_wdata;
    logic [3:0]  i_ls_bmask;
    logic        o_ls_gnt;
    logic        o_ls_rvalid;
    logic [31:0] o_ls_rdata;
    logic        o_mem_req;
    logic        o_mem_wren;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_ready;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_stall_fetch;
    logic        o_stall_memory;
    logic        o_busy;

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_STARVE(4)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_flush        (i_flush),
        .i_if_req       (i_if_req),
        .i_if_addr      (i_if_addr),
        .o_if_gnt       (o_if_gnt),
        .o_if_rvalid    (o_if_rvalid),
        .o_if_rdata     (o_if_rdata),
        .i_ls_req       (i_ls_req),
        .i_ls_wren      (i_ls_wren),
        .i_ls_addr      (i_ls_addr),
        .i_ls_wdata     (i_ls_wdata),
        .i_ls_bmask     (i_ls_bmask),
        .o_ls_gnt       (o_ls_gnt),
        .o_ls_rvalid    (o_ls_rvalid),
        .o_ls_rdata     (o_ls_rdata),
        .o_mem_req      (o_mem_req),
        .o_mem_wren     (o_mem_wren),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_bmask    (o_mem_bmask),
        .i_mem_ready    (i_mem_ready),
        .i_mem_rvalid   (i_mem_rvalid),
        .i_mem_rdata    (i_mem_rdata),
        .o_stall_fetch  (o_stall_fetch),
        .o_stall_memory (o_stall_memory),
        .o_busy         (o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int checks   = 0;
    int failures = 0;

    mem_txn_t mem_exp_q[$];
    rsp_t     rsp_exp_q[$];

    // Responder knobs and state.
    int          rdy_lat = 0;
    int          rv_lat  = 0;
    int          rdy_cnt = 0;
    int          pend_cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;

    // Output snapshot taken at the falling edge of each cycle.
    logic        s_if_gnt, s_if_rvalid, s_ls_gnt, s_ls_rvalid;
    logic        s_mem_req, s_mem_wren, s_stall_f, s_stall_m, s_busy;
    logic [31:0] s_mem_addr, s_mem_wdata, s_if_rdata;
    logic [3:0]  s_mem_bmask;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        if (a == 32'h0000_0300) return 32'h1234_5678;
        return {a[15:0], 16'h0000} ^ 32'h5A5A_0F0F ^ a;
    endfunction

    function automatic mem_txn_t fetch_txn(input logic [31:0] a);
        mem_txn_t t;
        t.wren = 1'b0; t.addr = a; t.wdata = '0; t.bmask = 4'hF;
        return t;
    endfunction

    function automatic mem_txn_t ls_txn(input logic w, input logic [31:0] a,
                                        input logic [31:0] d, input logic [3:0] m);
        mem_txn_t t;
        t.wren = w; t.addr = a; t.wdata = d; t.bmask = m;
        return t;
    endfunction

    function automatic rsp_t rsp(input logic is_ls, input logic [31:0] d);
        rsp_t r;
        r.is_ls = is_ls; r.data = d;
        return r;
    endfunction

    task automatic raise_if(input logic [31:0] a);
        i_if_req  = 1'b1;
        i_if_addr = a;
    endtask

    task automatic raise_ls(input mem_txn_t t);
        i_ls_req   = 1'b1;
        i_ls_wren  = t.wren;
        i_ls_addr  = t.addr;
        i_ls_wdata = t.wdata;
        i_ls_bmask = t.bmask;
    endtask

    // One cycle: sample and score at the falling edge, then after the next rising
    // edge update the memory responder and release requesters that are done.
    task automatic step();
        mem_txn_t mt;
        rsp_t     rt;
        @(negedge i_clk);
        s_if_gnt = o_if_gnt;     s_if_rvalid = o_if_rvalid; s_ls_gnt = o_ls_gnt;
        s_ls_rvalid = o_ls_rvalid; s_mem_req = o_mem_req;   s_mem_wren = o_mem_wren;
        s_mem_addr = o_mem_addr; s_mem_wdata = o_mem_wdata; s_mem_bmask = o_mem_bmask;
        s_stall_f = o_stall_fetch; s_stall_m = o_stall_memory; s_busy = o_busy;
        s_if_rdata = o_if_rdata;

        if (o_mem_req && i_mem_ready) begin
            if (mem_exp_q.size() == 0) begin
                check("mem_unexpected", 32'(o_mem_req & i_mem_ready), 32'd0);
            end else begin
                mt = mem_exp_q.pop_front();
                check("mem_wren",  32'(o_mem_wren),  32'(mt.wren));
                check("mem_addr",  o_mem_addr,       mt.addr);
                check("mem_bmask", 32'(o_mem_bmask), 32'(mt.bmask));
                if (mt.wren) check("mem_wdata", o_mem_wdata, mt.wdata);
            end
            if (!o_mem_wren) begin
                pend      = 1'b1;
                pend_addr = o_mem_addr;
                pend_cnt  = rv_lat;
            end
        end

        if (o_if_rvalid || o_ls_rvalid) begin
            check("rsp_single", 32'(o_if_rvalid & o_ls_rvalid), 32'd0);
            if (rsp_exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(o_if_rvalid | o_ls_rvalid), 32'd0);
            end else begin
                rt = rsp_exp_q.pop_front();
                check("rsp_port", 32'(o_ls_rvalid), 32'(rt.is_ls));
                check("rsp_data", rt.is_ls ? o_ls_rdata : o_if_rdata, rt.data);
            end
        end

        @(posedge i_clk);
        #1;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
        if (pend) begin
            if (pend_cnt == 0) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = mem_model(pend_addr);
                pend         = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (o_mem_req) begin
            if (rdy_cnt < rdy_lat) begin
                i_mem_ready = 1'b0;
                rdy_cnt++;
            end else begin
                i_mem_ready = 1'b1;
            end
        end else begin
            i_mem_ready = 1'b0;
            rdy_cnt     = 0;
        end
        if (s_if_rvalid) i_if_req = 1'b0;
        if (s_ls_rvalid || (s_ls_gnt && i_ls_wren)) i_ls_req = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((i_if_req || i_ls_req) && n < 200) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, 32'(i_if_req | i_ls_req), 32'd0);
        step();
    endtask

    initial begin
        mem_txn_t ls_seq[5];
        int ls_sent;
        int if_sent;
        int n;

        i_reset = 1'b0; i_flush = 1'b0;
        i_if_req = 1'b0; i_if_addr = '0;
        i_ls_req = 1'b0; i_ls_wren = 1'b0; i_ls_addr = '0; i_ls_wdata = '0; i_ls_bmask = '0;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;

        // Reset state.
        step();
        step();
        check("rst_mem_req",  32'(s_mem_req),   32'd0);
        check("rst_busy",     32'(s_busy),      32'd0);
        check("rst_mem_addr", s_mem_addr,       32'd0);
        check("rst_bmask",    32'(s_mem_bmask), 32'd0);
        i_reset = 1'b1;
        step();

        // Lone IF read: gnt at T1, data at T2.
        raise_if(32'h100);
        mem_exp_q.push_back(fetch_txn(32'h100));
        rsp_exp_q.push_back(rsp(1'b0, 32'h0050_0093));
        step();
        check("if1_t0_busy",  32'(s_busy),    32'd0);
        check("if1_t0_req",   32'(s_mem_req), 32'd0);
        check("if1_t0_stall", 32'(s_stall_f), 32'd1);
        step();
        check("if1_t1_req",   32'(s_mem_req), 32'd1);
        check("if1_t1_gnt",   32'(s_if_gnt),  32'd1);
        check("if1_t1_addr",  s_mem_addr,     32'h100);
        check("if1_t1_stall", 32'(s_stall_f), 32'd1);
        step();
        check("if1_t2_rvalid", 32'(s_if_rvalid), 32'd1);
        check("if1_t2_rdata",  s_if_rdata,       32'h0050_0093);
        check("if1_t2_stall",  32'(s_stall_f),   32'd0);
        step();
        check("if1_t3_busy", 32'(s_busy), 32'd0);

        // LS stores back to back against a waiting IF: IF wins the 5th arbitration,
        // then its cleared counter lets LS win again against a fresh IF request.
        for (int i = 0; i < 5; i++)
            ls_seq[i] = ls_txn(1'b1, 32'h5000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF ^ 4'(i));
        for (int i = 0; i < 4; i++) mem_exp_q.push_back(ls_seq[i]);
        mem_exp_q.push_back(fetch_txn(32'h200));
        mem_exp_q.push_back(ls_seq[4]);
        mem_exp_q.push_back(fetch_txn(32'h204));
        rsp_exp_q.push_back(rsp(1'b0, mem_model(32'h200)));
        rsp_exp_q.push_back(rsp(1'b0, mem_model(32'h204)));
        raise_if(32'h200);
        raise_ls(ls_seq[0]);
        ls_sent = 1;
        if_sent = 1;
        n = 0;
        while (n < 300) begin
            step();
            n++;
            if (!i_ls_req && ls_sent < 5) begin
                raise_ls(ls_seq[ls_sent]);
                ls_sent++;
            end
            if (!i_if_req && if_sent < 2) begin
                raise_if(32'h204);
                if_sent++;
            end
            if (ls_sent == 5 && if_sent == 2 && !i_ls_req && !i_if_req) break;
        end
        check("starve_timeout", 32'(i_if_req | i_ls_req), 32'd0);
        step();
        check("starve_all_seen", 32'(mem_exp_q.size()), 32'd0);

        // IF and LS load together: LS first.
        mem_exp_q.push_back(ls_txn(1'b0, 32'h2000, 32'h0, 4'hF));
        mem_exp_q.push_back(fetch_txn(32'h104));
        rsp_exp_q.push_back(rsp(1'b1, mem_model(32'h2000)));
        rsp_exp_q.push_back(rsp(1'b0, mem_model(32'h104)));
        raise_if(32'h104);
        raise_ls(ls_txn(1'b0, 32'h2000, 32'h0, 4'hF));
        drain("both");

        // Store with ready held low for three cycles.
        rdy_lat = 3;
        mem_exp_q.push_back(ls_txn(1'b1, 32'h7000, 32'hDEAD_BEEF, 4'hF));
        raise_ls(ls_txn(1'b1, 32'h7000, 32'hDEAD_BEEF, 4'hF));
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_req",    32'(s_mem_req),   32'd1);
            check("st_addr",   s_mem_addr,       32'h7000);
            check("st_wdata",  s_mem_wdata,      32'hDEAD_BEEF);
            check("st_wren",   32'(s_mem_wren),  32'd1);
            check("st_bmask",  32'(s_mem_bmask), 32'hF);
            check("st_nognt",  32'(s_ls_gnt),    32'd0);
            check("st_stallm", 32'(s_stall_m),   32'd1);
        end
        step();
        check("st_gnt",       32'(s_ls_gnt),    32'd1);
        check("st_gnt_stall", 32'(s_stall_m),   32'd0);
        check("st_norvalid",  32'(s_ls_rvalid), 32'd0);
        step();
        check("st_idle",      32'(s_busy),      32'd0);
        check("st_norvalid2", 32'(s_ls_rvalid), 32'd0);
        rdy_lat = 0;

        // Flush while LS owns the port, then flush in IDLE: neither affects delivery.
        i_flush = 1'b1;
        mem_exp_q.push_back(ls_txn(1'b0, 32'h2400, 32'h0, 4'h3));
        rsp_exp_q.push_back(rsp(1'b1, mem_model(32'h2400)));
        raise_ls(ls_txn(1'b0, 32'h2400, 32'h0, 4'h3));
        drain("flush_ls");
        mem_exp_q.push_back(fetch_txn(32'h108));
        rsp_exp_q.push_back(rsp(1'b0, mem_model(32'h108)));
        raise_if(32'h108);
        step();
        i_flush = 1'b0;
        drain("flush_idle");

        // Flush during IF WAIT: response completes downstream but is dropped.
        rv_lat = 2;
        mem_exp_q.push_back(fetch_txn(32'h300));
        raise_if(32'h300);
        step();
        step();
        i_flush = 1'b1;
        step();
        check("fl_wait_stall", 32'(s_stall_f), 32'd1);
        i_flush = 1'b0;
        step();
        step();
        check("fl_rvalid", 32'(s_if_rvalid), 32'd0);
        check("fl_stall",  32'(s_stall_f),   32'd1);
        check("fl_busy",   32'(s_busy),      32'd1);
        i_if_req = 1'b0;
        step();
        check("fl_idle", 32'(s_busy), 32'd0);

        // Reset pulse in WAIT; the late response must be ignored.
        rv_lat = 3;
        mem_exp_q.push_back(fetch_txn(32'h400));
        raise_if(32'h400);
        step();
        step();
        step();
        check("rw_wait_busy", 32'(s_busy), 32'd1);
        i_reset  = 1'b0;
        i_if_req = 1'b0;
        step();
        check("rw_req",    32'(s_mem_req),   32'd0);
        check("rw_busy",   32'(s_busy),      32'd0);
        check("rw_addr",   s_mem_addr,       32'd0);
        check("rw_wren",   32'(s_mem_wren),  32'd0);
        check("rw_bmask",  32'(s_mem_bmask), 32'd0);
        check("rw_stallf", 32'(s_stall_f),   32'd0);
        i_reset = 1'b1;
        step();
        step();
        check("rw_late_rvalid", 32'(s_if_rvalid), 32'd0);
        check("rw_late_busy",   32'(s_busy),      32'd0);
        check("rw_late_req",    32'(s_mem_req),   32'd0);
        rv_lat = 0;
        step();

        check("sb_mem_empty", 32'(mem_exp_q.size()), 32'd0);
        check("sb_rsp_empty", 32'(rsp_exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
